// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered UART transmitter.
// A synchronous write FIFO feeds a frame FSM (IDLE/START/DATA/PARITY/STOP)
// with an internal baud divider. Frames are sent back-to-back while the FIFO
// holds data.
// Optional feature macro: UART_TX_STOP2_EN adds the STOP2 port, which selects
// two stop bits. Without it, frames always use one stop bit.
module uart_tx_buffered #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         WR_DATA,
    input  logic                          WR_EN,
    output logic                          FULL,
    output logic                          EMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic                          OVF,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic [DIV_WIDTH-1:0]          BAUD_DIV,
`ifdef UART_TX_STOP2_EN
    input  logic                          STOP2,
`endif
    output logic                          TX_OUT,
    output logic                          BUSY
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  LAST_BIT   = 4'(DATA_WIDTH-1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  ovf;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Frame FSM state and per-frame latched configuration
    logic [2:0]            state;
    logic [DIV_WIDTH-1:0]  baud_cnt;
    logic [DIV_WIDTH-1:0]  div_lat;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_lat;
    logic                  par_bit_lat;
    logic                  stop2_lat;
    logic                  stop_second;
    logic                  tx_out;
    logic                  stop2_cfg;
    logic                  baud_done;
    logic                  stop_last;

`ifdef UART_TX_STOP2_EN
    assign stop2_cfg = STOP2;
`else
    assign stop2_cfg = 1'b0;
`endif

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign push      = WR_EN && !full;
    assign baud_done = (baud_cnt == div_lat);
    assign stop_last = !stop2_lat || stop_second;

    // Pop from IDLE as soon as data is present, or on the final STOP clock so the next start bit follows with no gap
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == ST_IDLE) begin
                pop = 1'b1;
            end else if (state == ST_STOP && baud_done && stop_last) begin
                pop = 1'b1;
            end
        end
    end

    // FIFO storage write; contents are deliberately left untouched by reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (WR_EN && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // Frame FSM: loads a word on pop, then walks start, data, parity and stop bits at the baud rate
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            div_lat     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            par_en_lat  <= 1'b0;
            par_bit_lat <= 1'b0;
            stop2_lat   <= 1'b0;
            stop_second <= 1'b0;
            tx_out      <= 1'b1;
        end else if (pop) begin
            shift_reg   <= mem[rd_ptr];
            par_bit_lat <= (^mem[rd_ptr]) ^ PAR_TYP;
            par_en_lat  <= PAR_EN;
            stop2_lat   <= stop2_cfg;
            div_lat     <= BAUD_DIV;
            state       <= ST_START;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            stop_second <= 1'b0;
            tx_out      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    tx_out   <= 1'b1;
                end
                ST_START: begin
                    if (baud_done) begin
                        state    <= ST_DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_out   <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            if (par_en_lat) begin
                                state  <= ST_PARITY;
                                tx_out <= par_bit_lat;
                            end else begin
                                state       <= ST_STOP;
                                stop_second <= 1'b0;
                                tx_out      <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 4'd1;
                            shift_reg <= shift_reg >> 1;
                            tx_out    <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_done) begin
                        state       <= ST_STOP;
                        baud_cnt    <= '0;
                        stop_second <= 1'b0;
                        tx_out      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (stop_last) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_second <= 1'b1;
                        end
                        tx_out <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                    tx_out   <= 1'b1;
                end
            endcase
        end
    end

    assign FULL   = full;
    assign EMPTY  = empty;
    assign LEVEL  = count;
    assign OVF    = ovf;
    assign TX_OUT = tx_out;
    assign BUSY   = (state != ST_IDLE) || !empty;

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered, parametrised UART transmitter for the UART subsystem. It replaces the bare single-word TX path with a synchronous write FIFO, an internal baud divider, and generalised frame formatting. Producers push words at system rate. The block serialises them back-to-back on `TX_OUT` with no idle gap between frames while the FIFO holds data.

## Interface
Parameters:
- `DATA_WIDTH`, 8 — bits per character, 5..9.
- `FIFO_DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `DIV_WIDTH`, 16 — width of the baud divisor.

Ports:
- `CLK` in 1 — single clock.
- `RST` in 1 — reset; synchronous and active-high. Clears all state on the next rising `CLK` edge.
- `WR_DATA` in DATA_WIDTH — word to enqueue.
- `WR_EN` in 1 — enqueue strobe; sampled on the rising edge.
- `FULL` out 1 — FIFO holds FIFO_DEPTH words.
- `EMPTY` out 1 — FIFO holds 0 words.
- `LEVEL` out $clog2(FIFO_DEPTH)+1 — current FIFO occupancy.
- `OVF` out 1 — sticky overflow flag; cleared only by `RST`.
- `PAR_EN` in 1 — parity bit enable.
- `PAR_TYP` in 1 — parity type: 0 = even, 1 = odd.
- `BAUD_DIV` in DIV_WIDTH — bit period is BAUD_DIV+1 clocks.
- `STOP2` in 1 — two stop bits. Present only with `UART_TX_STOP2_EN`.
- `TX_OUT` out 1 — serial line; idles high; driven from a register.
- `BUSY` out 1 — high when state ≠ IDLE or FIFO is not empty.

## Operation
FIFO:
- Write is accepted iff `WR_EN` && !`FULL`. `FULL` is evaluated before the edge, so a same-cycle pop does not rescue a write while full.
- A dropped write sets `OVF`.
- Pointers wrap modulo FIFO_DEPTH.
- A simultaneous push and pop leaves `LEVEL` unchanged.

Frame FSM states: IDLE → START → DATA → PARITY → STOP.
- **IDLE**
  - Drives `TX_OUT`=1.
  - If !`EMPTY`: pops the head into the shift register and latches `PAR_EN`, `PAR_TYP`, `STOP2` and `BAUD_DIV` for the whole frame. Then goes to START.
- **START**
  - Drives `TX_OUT`=0 for one bit period.
- **DATA**
  - Sends DATA_WIDTH bits, LSB first, one bit period each.
  - Goes to PARITY if the latched PAR_EN is 1, else to STOP.
- **PARITY**
  - Sends the parity bit for one bit period.
  - Even parity: bit = XOR of the data bits.
  - Odd parity: bit = inverted XOR of the data bits.
- **STOP**
  - Drives `TX_OUT`=1 for 1 bit period, or 2 if the latched STOP2 is 1.
  - On the final clock of STOP: if !`EMPTY`, pops the next word and enters START directly; otherwise enters IDLE.

Baud counter and frame length:
- A DIV_WIDTH-bit baud counter counts 0..BAUD_DIV.
- It is reset to 0 on every state entry and held at 0 in IDLE.
- A bit advances when counter == BAUD_DIV.
- `BAUD_DIV`=0 gives one clock per bit.
- Frame length = (1 + DATA_WIDTH + PAR_EN + stop bits) × (BAUD_DIV+1) clocks.
- Changing configuration inputs mid-frame has no effect until the next frame start.

Reset values:
- `TX_OUT`=1, `BUSY`=0, `FULL`=0, `EMPTY`=1, `LEVEL`=0, `OVF`=0.
- FSM = IDLE; FIFO pointers cleared. FIFO storage contents are not cleared.

Reset mid-frame:
- The frame is aborted and the FIFO is flushed.
- `TX_OUT`=1 from the edge that samples `RST`.

## Timing
- Write into an empty FIFO at edge n: `EMPTY` falls after edge n; the pop occurs at edge n+1; `TX_OUT` falls after edge n+1.
- Word-to-line latency is 2 edges.
- `FULL`, `EMPTY`, `LEVEL` and `OVF` update on the same edge as the push or pop.
- Back-to-back frames: the last stop clock is followed immediately by the next start bit, with zero idle clocks.
- `BUSY` falls on the edge where STOP→IDLE is taken with the FIFO empty.

## Configuration
- Macro: `UART_TX_STOP2_EN`.
- Defined: the `STOP2` port exists, and STOP lasts 1 or 2 bit periods according to the value latched at frame start.
- Undefined: the port is absent and STOP is always 1 bit period. All other behaviour is identical.

## Test plan
- **Basic frame.** DATA_WIDTH=8, BAUD_DIV=3, PAR_EN=0; write 0xA5.
  - `TX_OUT`: 0 for 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks. Total 40 clocks.
  - `BUSY` falls at the end.
- **Parity.** BAUD_DIV=1, PAR_EN=1, write 0x07.
  - PAR_TYP=0 → parity bit 1.
  - Repeat with PAR_TYP=1 → parity bit 0.
  - Frame is 22 clocks.
- **Overflow and back-to-back.** FIFO_DEPTH=8, BAUD_DIV=15; write 10 words on consecutive clocks.
  - Word 0 is popped at the 2nd edge; words 0..8 are accepted.
  - `FULL`=1 and `LEVEL`=8 after the 9th write; the 10th write is dropped and `OVF`=1.
  - 9 frames are emitted with no idle clock between them.
- **Two stop bits** (macro defined). STOP2=1, BAUD_DIV=2, write 0x00.
  - Stop level is high for 6 clocks.
  - Toggling STOP2 mid-frame does not change the current frame.
- **Reset mid-frame.** Assert `RST` for 1 clock during the 3rd data bit with 4 words queued.
  - `TX_OUT`=1, `LEVEL`=0, `EMPTY`=1, `OVF`=0 after that edge.
  - No further frames are emitted.
- **Minimum divisor.** BAUD_DIV=0, write 0x3C.
  - Frame is 10 clocks: 0,0,0,1,1,1,1,0,0,1.
